// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one 32-bit memory port between the instruction fetcher (i_*) and
// the load/store unit (d_*). Only one transaction is in flight at a time:
// IDLE picks a requester, ISSUE presents the latched request to memory until
// it is accepted, and WAIT routes the single response back to its owner.
//
// Data requests win by default. A 4-bit streak counter counts data grants
// made while a fetch was also waiting; once it reaches STREAK_MAX the next
// IDLE cycle with a pending fetch grants the fetch.
//
// Handshake semantics (both requester ports and the memory port):
//   A transfer happens on a posedge where valid && ready are both 1. The
//   requester holds valid and its fields stable until it sees ready. Ready
//   may depend combinationally on valid. rvalid is a one-cycle pulse with no
//   back-pressure; rdata is meaningful only while the matching rvalid is 1.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   i_valid/i_addr/i_ready  fetch request channel
//   i_rvalid/i_rdata        fetch response
//   d_valid/d_addr/d_wdata/d_wstrb/d_ready   load/store request channel
//                                            (d_wstrb == 0 means load)
//   d_rvalid/d_rdata        load/store response
//   mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_ready   memory request
//   mem_rvalid/mem_rdata    memory response
//   dbg_state               current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)

module mem_port_arbiter #(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    state_t      state;
    state_t      state_next;
    logic        owner_d;      // 1: outstanding transaction belongs to data side
    logic [3:0]  streak;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        grant_i;
    logic        grant_d;
    logic        streak_full;

    // Next-state and grant decision.
    always_comb begin
        state_next  = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        streak_full = (streak == STREAK_LIM);

        case (state)
            IDLE: begin
                if (i_valid && (!d_valid || streak_full)) begin
                    grant_i = 1'b1;
                end else if (d_valid) begin
                    grant_d = 1'b1;
                end
                if (grant_i || grant_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Any mem_rvalid here is ignored: memory never answers in
                // the cycle it accepts.
                if (mem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs are gated by reset so nothing is offered or
    // delivered while the core is held in reset, whatever the state is.
    always_comb begin
        i_ready   = reset && grant_i;
        d_ready   = reset && grant_d;
        mem_valid = reset && (state == ISSUE);
        i_rvalid  = reset && (state == WAIT) && mem_rvalid && !owner_d;
        d_rvalid  = reset && (state == WAIT) && mem_rvalid &&  owner_d;
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            streak  <= 4'd0;
            owner_d <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                owner_d <= 1'b0;
                addr_q  <= i_addr;
                wdata_q <= 32'd0;
                wstrb_q <= 4'd0;
                streak  <= 4'd0;
            end else if (grant_d) begin
                owner_d <= 1'b1;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                wstrb_q <= d_wstrb;
                // Only contended data grants count toward the fetch guard.
                if (i_valid && (streak < STREAK_LIM)) begin
                    streak <= streak + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Requester drivers feed the DUT from request
// queues, a memory model checks each accepted request against mem_q and
// returns its data, and a monitor pops exp_q on every response pulse.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_ready, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_valid, d_ready, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_valid, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STREAK_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dreq_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } mreq_t;

    logic [31:0] i_q[$];
    dreq_t       d_q[$];
    mreq_t       mem_q[$];
    logic [32:0] exp_q[$];   // {owner_is_data, rdata}

    int n_checks = 0;
    int n_fail   = 0;

    // memory model controls
    int   stall      = 0;
    int   resp_wait  = 0;
    bit   stray      = 1'b0;
    bit   pend       = 1'b0;
    int   last_valid_len = 0;

    // monitor state
    bit   busy    = 1'b0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   last_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        mem_q.push_back('{addr: addr, wdata: 32'd0, wstrb: 4'd0, rdata: rdata});
        exp_q.push_back({1'b0, rdata});
    endtask

    task automatic exp_data(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] rdata);
        mem_q.push_back('{addr: addr, wdata: wdata, wstrb: wstrb, rdata: rdata});
        exp_q.push_back({1'b1, rdata});
    endtask

    task automatic req_data(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
        d_q.push_back('{addr: addr, wdata: wdata, wstrb: wstrb});
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            done = (i_q.size() == 0) && (d_q.size() == 0) && (mem_q.size() == 0) &&
                   (exp_q.size() == 0) && !busy && !pend;
        end
        check("drain", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Requester drivers: hold valid/fields until a handshake is seen.
    initial begin
        bit ih, dh;
        logic [31:0] tmp_i;
        dreq_t tmp_d;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        forever begin
            @(negedge clk);
            ih = i_valid && i_ready;
            dh = d_valid && d_ready;
            @(posedge clk);
            #1;
            if (ih && i_q.size() > 0) tmp_i = i_q.pop_front();
            if (dh && d_q.size() > 0) tmp_d = d_q.pop_front();
            i_valid = (i_q.size() > 0);
            i_addr  = (i_q.size() > 0) ? i_q[0] : 32'd0;
            d_valid = (d_q.size() > 0);
            if (d_q.size() > 0) begin
                d_addr = d_q[0].addr; d_wdata = d_q[0].wdata; d_wstrb = d_q[0].wstrb;
            end
        end
    end

    // Memory model: accepts after `stall` cycles, answers `resp_wait`
    // cycles after the accept cycle (0 = the very next cycle).
    initial begin
        bit accepted, prev_stall;
        int cnt, vlen;
        logic [31:0] pend_data;
        mreq_t m, saved;
        accepted = 1'b0; prev_stall = 1'b0; cnt = 0; vlen = 0; pend_data = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rvalid = stray;
            mem_rdata  = 32'd0;
            mem_ready  = 1'b0;
            if (!reset) begin
                pend = 1'b0; accepted = 1'b0; prev_stall = 1'b0; vlen = 0;
            end else begin
                if (prev_stall) begin
                    check("mem_hold", {mem_valid, mem_addr[30:0]}, {1'b1, saved.addr[30:0]});
                    check("mem_hold_data", mem_wdata, saved.wdata);
                    check("mem_hold_strb", {28'd0, mem_wstrb}, {28'd0, saved.wstrb});
                end
                prev_stall = 1'b0;
                if (accepted) begin
                    pend = 1'b1; cnt = resp_wait; accepted = 1'b0;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = pend_data; pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (mem_valid) begin
                    vlen++;
                    if (stall > 0) begin
                        stall--;
                        prev_stall = 1'b1;
                        saved = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, rdata: 32'd0};
                    end else begin
                        mem_ready = 1'b1;
                        accepted  = 1'b1;
                        last_valid_len = vlen;
                        vlen = 0;
                        if (mem_q.size() == 0) begin
                            check("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
                        end else begin
                            m = mem_q.pop_front();
                            check("mem_addr", mem_addr, m.addr);
                            check("mem_wdata", mem_wdata, m.wdata);
                            check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m.wstrb});
                            pend_data = m.rdata;
                        end
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                check("reset_quiet", {27'd0, i_ready, d_ready, mem_valid, i_rvalid, d_rvalid}, 32'd0);
                busy = 1'b0;
            end else begin
                if (i_ready || d_ready) begin
                    check("one_ready", {31'd0, i_ready && d_ready}, 32'd0);
                    check("ready_when_busy", {31'd0, busy}, 32'd0);
                    if ((i_valid && i_ready) || (d_valid && d_ready)) begin
                        busy = 1'b1;
                        acc_cyc = cyc;
                    end
                end
                if (i_rvalid || d_rvalid) begin
                    check("one_rvalid", {31'd0, i_rvalid && d_rvalid}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_owner", {31'd0, d_rvalid}, {31'd0, e[32]});
                        check("resp_data", d_rvalid ? d_rdata : i_rdata, e[31:0]);
                    end
                    last_lat = cyc - acc_cyc;
                    busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;

        // Reset with both requesters pending; data must win after release.
        req_data(32'h0000_3000, 32'd0, 4'd0);
        i_q.push_back(32'h0000_0104);
        exp_data(32'h0000_3000, 32'd0, 4'd0, 32'h0000_0033);
        exp_fetch(32'h0000_0104, 32'h0000_0044);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("first_grant", {30'd0, i_ready, d_ready}, 32'd1);
        wait_drain();

        // Single fetch, immediate memory.
        i_q.push_back(32'h0000_0100);
        exp_fetch(32'h0000_0100, 32'h0000_0013);
        wait_drain();
        check("fetch_latency", last_lat, 32'd2);

        // Starvation guard: D,D,D,D,I,D,D,D,D,I.
        for (int k = 0; k < 8; k++) req_data(32'h1000 + 32'(4 * k), 32'(k), 4'd0);
        i_q.push_back(32'h0000_0400);
        i_q.push_back(32'h0000_0404);
        for (int k = 0; k < 4; k++) exp_data(32'h1000 + 32'(4 * k), 32'(k), 4'd0, 32'hD000_0000 + 32'(k));
        exp_fetch(32'h0000_0400, 32'h1000_0001);
        for (int k = 4; k < 8; k++) exp_data(32'h1000 + 32'(4 * k), 32'(k), 4'd0, 32'hD000_0000 + 32'(k));
        exp_fetch(32'h0000_0404, 32'h1000_0002);
        wait_drain();

        // Backpressure on a store.
        stall = 5;
        req_data(32'h0000_2000, 32'hA5A5_0F0F, 4'b0011);
        exp_data(32'h0000_2000, 32'hA5A5_0F0F, 4'b0011, 32'h0000_0000);
        wait_drain();
        check("bp_valid_len", last_valid_len, 32'd6);
        check("bp_latency", last_lat, 32'd7);

        // Reset while waiting for a response, then a stray response.
        resp_wait = 3;
        i_q.push_back(32'h0000_0300);
        mem_q.push_back('{addr: 32'h0000_0300, wdata: 32'd0, wstrb: 4'd0, rdata: 32'hBAD0_0300});
        for (int k = 0; k < 50 && !pend; k++) @(negedge clk);
        check("reached_wait", {31'd0, pend}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        resp_wait = 0;
        @(posedge clk);
        #1 stray = 1'b1;
        @(negedge clk);
        check("stray_ignored", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        @(posedge clk);
        #1 stray = 1'b0;
        i_q.push_back(32'h0000_0200);
        exp_fetch(32'h0000_0200, 32'hCAFE_0200);
        wait_drain();

        // Uncontended data grants leave the streak at 0.
        for (int k = 0; k < 3; k++) begin
            req_data(32'h5000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'b1111);
            exp_data(32'h5000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'b1111, 32'h5500_0000 + 32'(k));
        end
        wait_drain();
        // Contention afterwards still takes four data grants before the fetch.
        for (int k = 0; k < 5; k++) req_data(32'h6000 + 32'(4 * k), 32'd0, 4'd0);
        i_q.push_back(32'h0000_0500);
        for (int k = 0; k < 4; k++) exp_data(32'h6000 + 32'(4 * k), 32'd0, 4'd0, 32'h6600_0000 + 32'(k));
        exp_fetch(32'h0000_0500, 32'h0500_0500);
        exp_data(32'h6010, 32'd0, 4'd0, 32'h6600_0004);
        wait_drain();
        // Lone fetch.
        i_q.push_back(32'h0000_0600);
        exp_fetch(32'h0000_0600, 32'h0600_0600);
        wait_drain();
        check("lone_fetch_latency", last_lat, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
